// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, prescale and parity constants shared by the
// UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Unsupported prescale requests fall back to 16.
  function automatic logic [5:0] eff_prescale(
    input logic [5:0] p
  );
    logic [5:0] r;
    r = PRESCALE_16;
    if (p == PRESCALE_8 || p == PRESCALE_32)
      r = p;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: per-bit cycle counter; CLK, RST (sync, low),
// enable, Prescale in; edge_cnt and bit_end (last cycle of a bit) out.
module uart_tx_bit_timer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [5:0] Prescale,
  output logic [5:0] edge_cnt,
  output logic       bit_end
);

  logic [5:0] last;

  assign last    = Prescale - 6'd1;
  assign bit_end = enable && (edge_cnt == last);

  always_ff @(posedge CLK) begin
    if (!RST)
      edge_cnt <= '0;
    else if (!enable || edge_cnt == last)
      edge_cnt <= '0;
    else
      edge_cnt <= edge_cnt + 6'd1;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: frame FSM; CLK, RST, P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
// Prescale in; registered TX_OUT (idle high) and Busy out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT =
    BW'(DATA_WIDTH - 1);

  uart_state_e           state;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic [5:0]            presc_r;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_nxt;
  logic [5:0]            edge_cnt;
  logic                  bit_end;
  logic                  stop_last;
  logic                  accept;

  uart_tx_bit_timer u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (state != IDLE),
    .Prescale (presc_r),
    .edge_cnt (edge_cnt),
    .bit_end  (bit_end)
  );

  assign bit_nxt   = bit_cnt + BW'(1);
  assign stop_last = (state == STOP) &&
                     (edge_cnt == presc_r - 6'd1);
  // A request in the final stop cycle chains frames with no idle gap.
  assign accept    = DATA_VALID &&
                     (state == IDLE || stop_last);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      bit_cnt   <= '0;
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      presc_r   <= '0;
    end else if (accept) begin
      state     <= START;
      TX_OUT    <= 1'b0;
      Busy      <= 1'b1;
      bit_cnt   <= '0;
      data_r    <= P_DATA;
      par_en_r  <= PAR_EN;
      par_bit_r <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
      presc_r   <= eff_prescale(Prescale);
    end else if (bit_end) begin
      unique case (state)
        IDLE: ;
        START: begin
          state  <= DATA;
          TX_OUT <= data_r[0];
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (par_en_r) begin
              state  <= PARITY;
              TX_OUT <= par_bit_r;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_nxt;
            TX_OUT  <= data_r[bit_nxt];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
